// File: rtl/exe_stage_unit.sv
// -----------------------------------------------------------------------------
// exe_stage_unit
// Execute stage of the basic ARM pipeline. It consumes the ID/EX register
// fields, builds the second operand (Val2), runs the ALU, computes the branch
// target, and owns the NZCV status register and the EX/MEM pipeline register.
//
// Optional feature macro: FORWARDING_EN
//   When defined, sel_src1/sel_src2 pick each operand from the ID/EX value,
//   MEM_ALU_Res or WB_Value. When undefined, those ports do not exist.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   freeze                 holds EX/MEM and status registers (memory stall)
//   WB_EN_IN .. S_IN       control bits from ID/EX
//   EXE_CMD_IN             ALU command
//   PC_IN                  PC+4 of the instruction
//   Val_Rn_IN, Val_Rm_IN   register operands
//   imm_IN                 immediate operand select
//   Shift_operand_IN       12-bit shifter operand field
//   Signed_imm_24_IN       branch offset (words)
//   Dest_IN                destination register
//   Status_in              NZCV captured with the instruction
//   Branch_taken/addr      combinational branch outputs
//   Status_out             status register {N,Z,C,V}
//   WB_EN .. Dest          registered EX/MEM outputs
// -----------------------------------------------------------------------------
module exe_stage_unit #(
   parameter logic [3:0] STATUS_RST = 4'b0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        WB_EN_IN,
   input  logic        MEM_R_EN_IN,
   input  logic        MEM_W_EN_IN,
   input  logic        B_IN,
   input  logic        S_IN,
   input  logic [3:0]  EXE_CMD_IN,
   input  logic [31:0] PC_IN,
   input  logic [31:0] Val_Rn_IN,
   input  logic [31:0] Val_Rm_IN,
   input  logic        imm_IN,
   input  logic [11:0] Shift_operand_IN,
   input  logic [23:0] Signed_imm_24_IN,
   input  logic [3:0]  Dest_IN,
   input  logic [3:0]  Status_in,
`ifdef FORWARDING_EN
   input  logic [1:0]  sel_src1,
   input  logic [1:0]  sel_src2,
   input  logic [31:0] MEM_ALU_Res,
   input  logic [31:0] WB_Value,
`endif
   output logic        Branch_taken,
   output logic [31:0] Branch_addr,
   output logic [3:0]  Status_out,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic [31:0] ALU_Res,
   output logic [31:0] ST_Val,
   output logic [3:0]  Dest
);

   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_MVN = 4'b1001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000
   } alu_cmd_e;

   // Rotate right; a zero amount shifts left by 32, which yields 0 and so
   // leaves the value untouched.
   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
      return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
   endfunction

   // ---------------------------------------------------------------- operands
   logic [31:0] op_a;
   logic [31:0] op_rm;

`ifdef FORWARDING_EN
   always_comb begin
      unique case (sel_src1)
         2'b01:   op_a = MEM_ALU_Res;
         2'b10:   op_a = WB_Value;
         default: op_a = Val_Rn_IN;
      endcase
      unique case (sel_src2)
         2'b01:   op_rm = MEM_ALU_Res;
         2'b10:   op_rm = WB_Value;
         default: op_rm = Val_Rm_IN;
      endcase
   end
`else
   assign op_a  = Val_Rn_IN;
   assign op_rm = Val_Rm_IN;
`endif

   // -------------------------------------------------------------------- Val2
   logic [31:0] val2;
   logic [4:0]  sh_amt;

   assign sh_amt = Shift_operand_IN[11:7];

   // NOTE: every signal written in an always_comb gets a value on every path
   // (defaults first); a missing branch would otherwise infer a latch.
   always_comb begin
      val2 = op_rm;
      if (imm_IN) begin
         val2 = ror32({24'b0, Shift_operand_IN[7:0]}, {Shift_operand_IN[11:8], 1'b0});
      end else if (MEM_R_EN_IN || MEM_W_EN_IN) begin
         // Load/store offset is the raw 12-bit field.
         val2 = {20'b0, Shift_operand_IN};
      end else begin
         unique case (Shift_operand_IN[6:5])
            2'b00: val2 = op_rm << sh_amt;
            2'b01: val2 = op_rm >> sh_amt;
            2'b10: val2 = $signed(op_rm) >>> sh_amt;
            2'b11: val2 = ror32(op_rm, sh_amt);
         endcase
      end
   end

   // --------------------------------------------------------------------- ALU
   logic [31:0] res;
   logic [32:0] sum;
   logic        flag_c;
   logic        flag_v;
   logic        cin;

   assign cin = Status_in[1];

   // Subtract forms are computed as A + ~B + carry so that bit 32 is the
   // ARM "no borrow" carry directly.
   always_comb begin
      res    = 32'b0;
      sum    = 33'b0;
      flag_c = Status_in[1];
      flag_v = Status_in[0];
      case (alu_cmd_e'(EXE_CMD_IN))
         CMD_MOV: res = val2;
         CMD_MVN: res = ~val2;
         CMD_ADD, CMD_ADC: begin
            sum    = {1'b0, op_a} + {1'b0, val2}
                   + {32'b0, (EXE_CMD_IN == CMD_ADC) ? cin : 1'b0};
            res    = sum[31:0];
            flag_c = sum[32];
            flag_v = (op_a[31] == val2[31]) && (res[31] != op_a[31]);
         end
         CMD_SUB, CMD_SBC: begin
            sum    = {1'b0, op_a} + {1'b0, ~val2}
                   + {32'b0, (EXE_CMD_IN == CMD_SBC) ? cin : 1'b1};
            res    = sum[31:0];
            flag_c = sum[32];
            flag_v = (op_a[31] != val2[31]) && (res[31] != op_a[31]);
         end
         CMD_AND: res = op_a & val2;
         CMD_ORR: res = op_a | val2;
         CMD_EOR: res = op_a ^ val2;
         default: res = 32'b0;
      endcase
   end

   // N and Z of the incoming status are always recomputed, never passed on.
   logic unused_status_nz;
   assign unused_status_nz = ^Status_in[3:2];

   // ------------------------------------------------------------------ branch
   assign Branch_taken = B_IN;
   assign Branch_addr  = PC_IN + {{6{Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

   // --------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         Status_out <= STATUS_RST;
      end else if (S_IN && !freeze) begin
         Status_out <= {res[31], (res == 32'b0), flag_c, flag_v};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         WB_EN    <= 1'b0;
         MEM_R_EN <= 1'b0;
         MEM_W_EN <= 1'b0;
         ALU_Res  <= 32'b0;
         ST_Val   <= 32'b0;
         Dest     <= 4'b0;
      end else if (!freeze) begin
         WB_EN    <= WB_EN_IN;
         MEM_R_EN <= MEM_R_EN_IN;
         MEM_W_EN <= MEM_W_EN_IN;
         ALU_Res  <= res;
         ST_Val   <= op_rm;
         Dest     <= Dest_IN;
      end
   end

endmodule

// File: tb/tb_exe_stage_unit.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_unit
// Directed-vector bench for exe_stage_unit. Expected values are hand-computed.
// Build with +define+FORWARDING_EN to include the operand-forwarding steps.
// -----------------------------------------------------------------------------
module tb_exe_stage_unit;

   localparam logic [3:0] ST_RST = 4'b1010;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN;
   logic [3:0]  EXE_CMD_IN;
   logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
   logic        imm_IN;
   logic [11:0] Shift_operand_IN;
   logic [23:0] Signed_imm_24_IN;
   logic [3:0]  Dest_IN, Status_in;
`ifdef FORWARDING_EN
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] MEM_ALU_Res, WB_Value;
`endif
   logic        Branch_taken;
   logic [31:0] Branch_addr;
   logic [3:0]  Status_out;
   logic        WB_EN, MEM_R_EN, MEM_W_EN;
   logic [31:0] ALU_Res, ST_Val;
   logic [3:0]  Dest;

   int vectors    = 0;
   int miscompares = 0;

   exe_stage_unit #(.STATUS_RST(ST_RST)) dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
      .B_IN(B_IN), .S_IN(S_IN), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
      .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
      .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
      .Dest_IN(Dest_IN), .Status_in(Status_in),
`ifdef FORWARDING_EN
      .sel_src1(sel_src1), .sel_src2(sel_src2),
      .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
`endif
      .Branch_taken(Branch_taken), .Branch_addr(Branch_addr),
      .Status_out(Status_out), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
      .MEM_W_EN(MEM_W_EN), .ALU_Res(ALU_Res), .ST_Val(ST_Val), .Dest(Dest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      freeze = 0; WB_EN_IN = 0; MEM_R_EN_IN = 0; MEM_W_EN_IN = 0; B_IN = 0; S_IN = 0;
      EXE_CMD_IN = 4'b0000; PC_IN = 0; Val_Rn_IN = 0; Val_Rm_IN = 0; imm_IN = 0;
      Shift_operand_IN = 0; Signed_imm_24_IN = 0; Dest_IN = 0; Status_in = 0;
`ifdef FORWARDING_EN
      sel_src1 = 2'b00; sel_src2 = 2'b00; MEM_ALU_Res = 0; WB_Value = 0;
`endif
   endtask

   initial begin
      // ---- reset with every input nonzero, freeze also high
      rst = 1; freeze = 1; WB_EN_IN = 1; MEM_R_EN_IN = 1; MEM_W_EN_IN = 1; B_IN = 1;
      S_IN = 1; EXE_CMD_IN = 4'b0010; PC_IN = 32'h44; Val_Rn_IN = 32'h1111;
      Val_Rm_IN = 32'h2222; imm_IN = 1; Shift_operand_IN = 12'h3AB;
      Signed_imm_24_IN = 24'h12; Dest_IN = 4'hF; Status_in = 4'hF;
`ifdef FORWARDING_EN
      sel_src1 = 2'b01; sel_src2 = 2'b10; MEM_ALU_Res = 32'h5; WB_Value = 32'h6;
`endif
      tick();
      check("rst_alu",    ALU_Res,    32'h0);
      check("rst_stval",  ST_Val,     32'h0);
      check("rst_dest",   {28'b0, Dest}, 32'h0);
      check("rst_ctl",    {29'b0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'h0);
      check("rst_status", {28'b0, Status_out}, {28'b0, ST_RST});

      // ---- ADD overflow: 7FFFFFFF + 1
      rst = 0; idle_inputs();
      EXE_CMD_IN = 4'b0010; S_IN = 1; WB_EN_IN = 1; Val_Rn_IN = 32'h7FFFFFFF;
      Val_Rm_IN = 32'h1234; imm_IN = 1; Shift_operand_IN = 12'h001; Dest_IN = 4'd3;
      tick();
      check("add_res",    ALU_Res, 32'h80000000);
      check("add_status", {28'b0, Status_out}, 32'h9);
      check("add_stval",  ST_Val, 32'h1234);
      check("add_dest",   {28'b0, Dest}, 32'd3);
      check("add_wb",     {31'b0, WB_EN}, 32'h1);

      // ---- SUB 5-5, LSL 0
      idle_inputs();
      EXE_CMD_IN = 4'b0100; S_IN = 1; Val_Rn_IN = 5; Val_Rm_IN = 5; Dest_IN = 4'd4;
      tick();
      check("sub_res",    ALU_Res, 32'h0);
      check("sub_status", {28'b0, Status_out}, 32'h6);

      // ---- freeze holds results and status
      idle_inputs();
      freeze = 1; EXE_CMD_IN = 4'b0010; S_IN = 1; WB_EN_IN = 1; Val_Rn_IN = 1;
      imm_IN = 1; Shift_operand_IN = 12'h001; Dest_IN = 4'd9;
      tick();
      check("frz_res",    ALU_Res, 32'h0);
      check("frz_status", {28'b0, Status_out}, 32'h6);
      check("frz_dest",   {28'b0, Dest}, 32'd4);
      check("frz_wb",     {31'b0, WB_EN}, 32'h0);
      freeze = 0;
      tick();
      check("unfrz_res",    ALU_Res, 32'h2);
      check("unfrz_status", {28'b0, Status_out}, 32'h0);
      check("unfrz_dest",   {28'b0, Dest}, 32'd9);

      // ---- MOV with rotated immediate, S=0 keeps status
      idle_inputs();
      EXE_CMD_IN = 4'b0001; imm_IN = 1; Shift_operand_IN = 12'h4FF;
      tick();
      check("mov_rot",      ALU_Res, 32'hFF000000);
      check("mov_nostatus", {28'b0, Status_out}, 32'h0);

      // ---- MOV register ASR #4
      idle_inputs();
      EXE_CMD_IN = 4'b0001; Val_Rm_IN = 32'h80000000; Shift_operand_IN = 12'h240;
      tick();
      check("asr4",       ALU_Res, 32'hF8000000);
      check("asr_stval",  ST_Val, 32'h80000000);

      // ---- MOV register ROR #4 and LSR #31
      idle_inputs();
      EXE_CMD_IN = 4'b0001; Val_Rm_IN = 32'h000000F1; Shift_operand_IN = 12'h260;
      tick();
      check("ror4", ALU_Res, 32'h1000000F);
      Val_Rm_IN = 32'h80000000; Shift_operand_IN = 12'hFA0;
      tick();
      check("lsr31", ALU_Res, 32'h1);

      // ---- MVN immediate
      idle_inputs();
      EXE_CMD_IN = 4'b1001; imm_IN = 1; Shift_operand_IN = 12'h0FF;
      tick();
      check("mvn", ALU_Res, 32'hFFFFFF00);

      // ---- LDR address uses the raw 12-bit offset
      idle_inputs();
      EXE_CMD_IN = 4'b0010; MEM_R_EN_IN = 1; WB_EN_IN = 1; Val_Rn_IN = 32'h1000;
      Shift_operand_IN = 12'hFFF;
      tick();
      check("ldr_addr", ALU_Res, 32'h1FFF);
      check("ldr_ren",  {31'b0, MEM_R_EN}, 32'h1);

      // ---- ADC with carry in: FFFFFFFF + 1 + 1
      idle_inputs();
      EXE_CMD_IN = 4'b0011; S_IN = 1; Val_Rn_IN = 32'hFFFFFFFF; imm_IN = 1;
      Shift_operand_IN = 12'h001; Status_in = 4'b0010;
      tick();
      check("adc_res",    ALU_Res, 32'h1);
      check("adc_status", {28'b0, Status_out}, 32'h2);

      // ---- SBC with C=0: 5 - 3 - 1
      idle_inputs();
      EXE_CMD_IN = 4'b0101; S_IN = 1; Val_Rn_IN = 5; imm_IN = 1;
      Shift_operand_IN = 12'h003; Status_in = 4'b0000;
      tick();
      check("sbc_res",    ALU_Res, 32'h1);
      check("sbc_status", {28'b0, Status_out}, 32'h2);

      // ---- EOR: C/V come from Status_in
      idle_inputs();
      EXE_CMD_IN = 4'b1000; S_IN = 1; Val_Rn_IN = 32'hF0F0F0F0;
      Val_Rm_IN = 32'h0F0F0F0F; Status_in = 4'b0011;
      tick();
      check("eor_res",    ALU_Res, 32'hFFFFFFFF);
      check("eor_status", {28'b0, Status_out}, 32'hB);

      // ---- AND / ORR
      idle_inputs();
      EXE_CMD_IN = 4'b0110; Val_Rn_IN = 32'hFF00FF00; Val_Rm_IN = 32'h0FF00FF0;
      tick();
      check("and", ALU_Res, 32'h0F000F00);
      EXE_CMD_IN = 4'b0111;
      tick();
      check("orr", ALU_Res, 32'hFFF0FFF0);

      // ---- undefined command: result 0, Z set, C/V from Status_in
      idle_inputs();
      EXE_CMD_IN = 4'b1111; S_IN = 1; Val_Rn_IN = 32'h1234; Val_Rm_IN = 32'h5678;
      Status_in = 4'b0001;
      tick();
      check("undef_res",    ALU_Res, 32'h0);
      check("undef_status", {28'b0, Status_out}, 32'h5);

      // ---- branch targets (combinational)
      idle_inputs();
      B_IN = 1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE;
      #1;
      check("br_taken", {31'b0, Branch_taken}, 32'h1);
      check("br_back",  Branch_addr, 32'h000000F8);
      PC_IN = 32'hFFFFFFFC; Signed_imm_24_IN = 24'h000001;
      #1;
      check("br_wrap", Branch_addr, 32'h0);
      B_IN = 0;
      #1;
      check("br_not", {31'b0, Branch_taken}, 32'h0);

      // ---- reset during a stall
      idle_inputs();
      EXE_CMD_IN = 4'b0001; imm_IN = 1; Shift_operand_IN = 12'h055; WB_EN_IN = 1;
      tick();
      check("pre_rst_res", ALU_Res, 32'h55);
      freeze = 1; rst = 1;
      tick();
      check("stall_rst_res",    ALU_Res, 32'h0);
      check("stall_rst_status", {28'b0, Status_out}, {28'b0, ST_RST});
      rst = 0;

`ifdef FORWARDING_EN
      // ---- forwarding of A from MEM
      idle_inputs();
      EXE_CMD_IN = 4'b0010; sel_src1 = 2'b01; MEM_ALU_Res = 10; Val_Rn_IN = 99;
      imm_IN = 1; Shift_operand_IN = 12'h001;
      tick();
      check("fwd_a_mem", ALU_Res, 32'd11);
      // ---- forwarding of store data from WB
      idle_inputs();
      EXE_CMD_IN = 4'b0010; MEM_W_EN_IN = 1; sel_src2 = 2'b10;
      WB_Value = 32'hCAFEBABE; Val_Rm_IN = 32'h1;
      tick();
      check("fwd_st_wb", ST_Val, 32'hCAFEBABE);
      // ---- selector 11 behaves as 00
      idle_inputs();
      EXE_CMD_IN = 4'b0010; sel_src1 = 2'b11; sel_src2 = 2'b11; Val_Rn_IN = 7;
      Val_Rm_IN = 3; MEM_ALU_Res = 100; WB_Value = 200;
      tick();
      check("fwd_sel11", ALU_Res, 32'd10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
